// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, frame width
// and the processor select-bus codes.
package loader_pkg;

  localparam int unsigned FRAME_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    GAP,
    RUN_LO,
    RUN_HI
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_IMEM = 2'b01,
    SEL_DMEM = 2'b10,
    SEL_RUN  = 2'b11
  } sel_t;

endpackage

// File: rtl/frame_serializer.sv
// Load-and-shift-right frame register with a bit counter; the LSB of the
// register is the serial bit, so frame bit k appears in shift cycle k.
module frame_serializer
  import loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [FRAME_W-1:0] frame,
  output logic               serial,
  output logic               last
);

  logic [FRAME_W-1:0] shreg;
  logic [3:0]         cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= frame;
      cnt   <= '0;
    end else if (shift) begin
      shreg <= {1'b0, shreg[FRAME_W-1:1]};
      cnt   <= cnt + 4'd1;
    end
  end

  assign serial = shreg[0];
  assign last   = (cnt == 4'(FRAME_W - 1));

endmodule

// File: rtl/prog_loader.sv
// Serial program/data loader and run controller for an attached processor.
// Optional run watchdog enabled by defining LOADER_TIMEOUT_EN.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned RUN_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_target,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_data,
  input  logic       run_valid,
  output logic       run_ready,
  output logic       run_done,
  output logic       run_timeout,
  input  logic       done_in,
  output logic [1:0] sel_out,
  output logic       mosi_out
);

  if (GAP_CYCLES < 2 || GAP_CYCLES > 15 || RUN_TIMEOUT < 1 || RUN_TIMEOUT > 255) begin : g_param_check
    $error("prog_loader: GAP_CYCLES or RUN_TIMEOUT out of range");
  end

  state_t     state, state_next;
  logic       target;
  logic [3:0] gap_cnt;
  logic       shift_en;
  logic       ser_bit;
  logic       ser_last;
  logic       finish;
  logic       expire;

  frame_serializer u_ser (
    .clk    (clk),
    .rst    (rst),
    .load   (req_ready),
    .shift  (shift_en),
    .frame  ({req_data, req_addr}),
    .serial (ser_bit),
    .last   (ser_last)
  );

  assign finish = (state == RUN_HI) && done_in;

`ifdef LOADER_TIMEOUT_EN
  logic [7:0] run_cnt;
  logic       timeout_q;

  always_ff @(posedge clk) begin
    if (rst)
      run_cnt <= '0;
    else if (run_ready)
      run_cnt <= '0;
    else if (state == RUN_LO || state == RUN_HI)
      run_cnt <= run_cnt + 8'd1;
  end

  // A completion seen in the final allowed cycle wins over the abort.
  assign expire = (state == RUN_LO || state == RUN_HI) &&
                  (run_cnt == 8'(RUN_TIMEOUT - 1)) && !finish;

  always_ff @(posedge clk) begin
    if (rst)
      timeout_q <= 1'b0;
    else if (finish)
      timeout_q <= 1'b0;
    else if (expire)
      timeout_q <= 1'b1;
  end

  assign run_timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign run_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target   <= 1'b0;
      gap_cnt  <= '0;
      run_done <= 1'b0;
    end else begin
      if (req_ready)
        target <= req_target;
      gap_cnt  <= (state == GAP) ? gap_cnt + 4'd1 : '0;
      run_done <= finish || expire;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (req_ready)
          state_next = SHIFT;
        else if (run_ready)
          state_next = RUN_LO;
      end
      SHIFT:  if (ser_last) state_next = GAP;
      GAP:    if (gap_cnt == 4'(GAP_CYCLES - 1)) state_next = IDLE;
      RUN_LO: begin
        if (expire)
          state_next = IDLE;
        else if (!done_in)
          state_next = RUN_HI;
      end
      RUN_HI: if (finish || expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    run_ready = 1'b0;
    sel_out   = SEL_NONE;
    mosi_out  = 1'b0;
    shift_en  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = req_valid && !rst;
        run_ready = run_valid && !req_valid && !rst;
      end
      SHIFT: begin
        sel_out  = target ? SEL_DMEM : SEL_IMEM;
        mosi_out = ser_bit;
        shift_en = 1'b1;
      end
      RUN_LO: sel_out = SEL_RUN;
      // Enable falls combinationally with done_in so the processor cannot relaunch.
      RUN_HI: sel_out = SEL_RUN & {2{~done_in}};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected frames/runs,
// a negedge monitor decodes the select bus like the processor would.
module tb_prog_loader;

  localparam int G  = 2;
  localparam int RT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_target = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       run_valid = 1'b0;
  logic       run_ready;
  logic       run_done;
  logic       run_timeout;
  logic       done_in = 1'b1;
  logic [1:0] sel_out;
  logic       mosi_out;

  prog_loader #(.GAP_CYCLES(G), .RUN_TIMEOUT(RT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_target  (req_target),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .run_valid   (run_valid),
    .run_ready   (run_ready),
    .run_done    (run_done),
    .run_timeout (run_timeout),
    .done_in     (done_in),
    .sel_out     (sel_out),
    .mosi_out    (mosi_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tgt;
    logic [3:0] addr;
    logic [7:0] data;
  } frame_t;

  typedef struct {
    int   cnt;
    logic to;
  } run_t;

  int nvec = 0;
  int nerr = 0;

  frame_t fq[$];
  run_t   rq[$];

  logic [7:0] imem_r[16];
  logic [7:0] dmem_r[16];
  logic [7:0] imem_p[16];
  logic [7:0] dmem_p[16];

  function automatic void chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- monitor / processor model ----------------
  logic [1:0]  fsel = '0;
  int          nbits = 0;
  logic [15:0] bits = '0;
  bit          fend = 1'b0;
  bit          held = 1'b0;
  int          pos = 0;
  int          rcnt = 0;
  bit          after_rst = 1'b0;
  frame_t      mf;
  run_t        mr;

  always @(negedge clk) begin
    if (rst) begin
      nbits     = 0;
      bits      = '0;
      fsel      = '0;
      fend      = 1'b0;
      rcnt      = 0;
      after_rst = 1'b1;
    end else begin
      if (after_rst) begin
        chk("sel_after_rst", int'(sel_out), 0);
        chk("mosi_after_rst", int'(mosi_out), 0);
        after_rst = 1'b0;
      end
      if (req_ready && run_ready)
        chk("ready_exclusive", 1, 0);

      if (sel_out == 2'b01 || sel_out == 2'b10) begin
        if (nbits == 0)
          fsel = sel_out;
        else if (sel_out != fsel)
          chk("sel_stable", int'(sel_out), int'(fsel));
        if (nbits < 16)
          bits[nbits] = mosi_out;
        nbits++;
      end else if (nbits > 0) begin
        if (fq.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          mf = fq.pop_front();
          chk("frame_bits", nbits, 12);
          chk("frame_target", int'(fsel == 2'b10), int'(mf.tgt));
          chk("frame_addr", int'(bits[3:0]), int'(mf.addr));
          chk("frame_data", int'(bits[11:4]), int'(mf.data));
        end
        if (nbits == 12) begin
          if (fsel == 2'b10) dmem_p[bits[3:0]] = bits[11:4];
          else               imem_p[bits[3:0]] = bits[11:4];
        end
        nbits = 0;
        fend  = 1'b1;
        held  = 1'b1;
        pos   = 0;
      end

      if (fend) begin
        held = held && (req_valid || run_valid);
        if (req_ready || run_ready) begin
          if (held) chk("first_idle_cycle", pos, G);
          else      chk("ready_after_gap", int'(pos >= G), 1);
          fend = 1'b0;
        end else if (pos < G) begin
          chk("gap_sel", int'(sel_out), 0);
          chk("gap_mosi", int'(mosi_out), 0);
        end
        pos++;
      end

      if (sel_out == 2'b11)
        rcnt++;
      if (run_done) begin
        if (rq.size() == 0) begin
          chk("unexpected_run_done", 1, 0);
        end else begin
          mr = rq.pop_front();
          chk("run_enable_cycles", rcnt, mr.cnt);
          chk("run_timeout_flag", int'(run_timeout), int'(mr.to));
        end
        rcnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready(input bit is_run, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (is_run ? run_ready : req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok)
      chk(is_run ? "run_accept_timeout" : "load_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic tgt, input logic [3:0] a, input logic [7:0] d, input bit abort);
    bit ok;
    req_valid  = 1'b1;
    req_target = tgt;
    req_addr   = a;
    req_data   = d;
    wait_ready(1'b0, ok);
    if (ok && !abort) begin
      fq.push_back('{tgt, a, d});
      if (tgt) dmem_r[a] = d;
      else     imem_r[a] = d;
    end
  endtask

  // Processor stays idle 2 cycles after launch, is busy for busy_len cycles, then idles.
  task automatic run(input int busy_len);
    bit   ok;
    run_t r;
    run_valid = 1'b1;
    wait_ready(1'b1, ok);
    run_valid = 1'b0;
    if (ok) begin
      r.cnt = busy_len + 2;
      r.to  = 1'b0;
`ifdef LOADER_TIMEOUT_EN
      if (busy_len + 2 >= RT) begin
        r.cnt = RT;
        r.to  = 1'b1;
      end
`endif
      rq.push_back(r);
      repeat (2) begin @(posedge clk); #1; end
      done_in = 1'b0;
      repeat (busy_len) begin @(posedge clk); #1; end
      done_in = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, nvec=%0d", nvec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      imem_r[i] = '0; dmem_r[i] = '0; imem_p[i] = '0; dmem_p[i] = '0;
    end

    // Reset with both requests asserted: nothing may be accepted.
    rst = 1'b1; req_valid = 1'b1; run_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_run_ready", int'(run_ready), 0);
    chk("rst_sel", int'(sel_out), 0);
    chk("rst_mosi", int'(mosi_out), 0);
    chk("rst_run_done", int'(run_done), 0);
    chk("rst_run_timeout", int'(run_timeout), 0);
    @(posedge clk); #1;
    req_valid = 1'b0; run_valid = 1'b0; rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Single imem load, inputs scrambled while shifting.
    load(1'b0, 4'h3, 8'hA5, 1'b0);
    req_valid = 1'b0; req_addr = 4'hF; req_data = 8'h00; req_target = 1'b1;
    repeat (20) begin @(posedge clk); #1; end

    // Back-to-back dmem then imem loads.
    load(1'b1, 4'hC, 8'h7F, 1'b0);
    load(1'b0, 4'h5, 8'h3C, 1'b0);
    req_valid = 1'b0;

    // Load and run requested together: load first, run on the first idle cycle.
    run_valid = 1'b1;
    load(1'b1, 4'h2, 8'h99, 1'b0);
    req_valid = 1'b0;
    run(20);

    // Run length boundaries around the watchdog limit, then a short run.
    run(RT - 3);
    run(30);
    run(1);

    // Reset mid-frame: no write, no run_done.
    load(1'b0, 4'h7, 8'hEE, 1'b1);
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end

    // Randomised mix of loads (sometimes back-to-back) and runs.
    for (int n = 0; n < 30; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 7) begin
        load(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), 1'b0);
        if ($urandom_range(0, 1) == 1) begin
          req_valid  = 1'b0;
          req_addr   = 4'($urandom);
          req_data   = 8'($urandom);
          req_target = ~req_target;
        end
      end else begin
        req_valid = 1'b0;
        run(int'($urandom_range(1, 12)));
      end
    end
    req_valid = 1'b0;
    repeat (30) begin @(posedge clk); #1; end

    chk("frames_outstanding", fq.size(), 0);
    chk("runs_outstanding", rq.size(), 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("imem[%0d]", i), int'(imem_p[i]), int'(imem_r[i]));
      chk($sformatf("dmem[%0d]", i), int'(dmem_p[i]), int'(dmem_r[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
